// File: rtl/uart_rx_stream_if.sv
// Byte stream from the UART receiver: valid/ready data plus one-cycle error pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_stream_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output m_data, output m_valid, output frame_err, output overrun,
                  output parity_err, input m_ready);
  modport slave  (input m_data, input m_valid, input frame_err, input overrun,
                  input parity_err, output m_ready);
`else
  modport master (output m_data, output m_valid, output frame_err, output overrun,
                  input m_ready);
  modport slave  (input m_data, input m_valid, input frame_err, input overrun,
                  output m_ready);
`endif
endinterface

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver (8E1/8O1 with UART_RX_PARITY_EN) into a one-entry valid/ready holding register;
// byte valid 1 clk after the stop-bit sample; a byte completed while the register is held is dropped with overrun.
module uart_rx_stream #(
  parameter int clk_freq = 50000000,
  parameter int uart_bps = 115200
`ifdef UART_RX_PARITY_EN
  , parameter bit parity_odd = 1'b0
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rxd,
  uart_rx_stream_if.master  m_if
);
  localparam int BPS_CNT = clk_freq / uart_bps;
  localparam int HALF    = BPS_CNT / 2;
  localparam int CW      = $clog2(BPS_CNT);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(HALF - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_s_q, rx_d_q;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            deliver, load, sample;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
`endif

  assign sample = (cnt_q == SAMPLE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_meta_q    <= uart_rxd;
      rx_s_q       <= rx_meta_q;
      rx_d_q       <= rx_s_q;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    deliver      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_d_q && !rx_s_q) state_d = START;
      end
      START: begin
        // Ending at the start-bit midpoint puts every later sample mid-bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          cnt_d     = '0;
          par_bad_d = ((^shift_q) ^ rx_s_q) != parity_odd;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           deliver      = 1'b1;
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A slot frees up in the same cycle the held byte is taken.
    load      = deliver && (!m_valid_q || m_if.m_ready);
    overrun_d = deliver && !load;
    m_data_d  = load ? shift_q : m_data_q;
    if (load)                          m_valid_d = 1'b1;
    else if (m_valid_q && m_if.m_ready) m_valid_d = 1'b0;
    else                               m_valid_d = m_valid_q;
  end

  assign m_if.m_data    = m_data_q;
  assign m_if.m_valid   = m_valid_q;
  assign m_if.frame_err = frame_err_q;
  assign m_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign m_if.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: frames bit-banged onto uart_rxd, delivered bytes checked against a queue.
module tb_uart_rx_stream;
  localparam int BPS = 50000000 / 115200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rxd = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   fe_cnt = 0, ov_cnt = 0, xfer_cnt = 0, pe_cnt = 0;
  int   fe0, ov0, x0, pe0;
  logic [7:0] exp_q[$];

  uart_rx_stream_if m_if ();

  uart_rx_stream dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .m_if     (m_if)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    uart_rxd = v;
    repeat (BPS) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par);
`else
    if (par) begin end
`endif
    bit_out(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; x0 = xfer_cnt; pe0 = pe_cnt;
  endtask

  // Scoreboard consumer: every transfer must match the oldest expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_if.frame_err) fe_cnt++;
      if (m_if.overrun)   ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (m_if.parity_err) pe_cnt++;
`endif
      if (m_if.m_valid && m_if.m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("spurious_valid", 32'(m_if.m_valid), 32'd0);
        else                   check("rx_byte", 32'(m_if.m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    m_if.m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_m_valid",   32'(m_if.m_valid),   32'd0);
    check("rst_m_data",    32'(m_if.m_data),    32'd0);
    check("rst_frame_err", 32'(m_if.frame_err), 32'd0);
    check("rst_overrun",   32'(m_if.overrun),   32'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Single byte with consumer ready
    m_if.m_ready = 1'b1;
    snap();
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b0, 1'b1);
    repeat (BPS) @(posedge clk);
    #1;
    check("single_xfers",   32'(xfer_cnt - x0), 32'd1);
    check("single_fe",      32'(fe_cnt - fe0),  32'd0);
    check("single_ov",      32'(ov_cnt - ov0),  32'd0);

    // Back-pressure: second byte must be dropped with overrun
    m_if.m_ready = 1'b0;
    snap();
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0, 1'b1);
    send(8'hC3, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_valid_held", 32'(m_if.m_valid),   32'd1);
    check("bp_data_held",  32'(m_if.m_data),    32'h3C);
    check("bp_overrun",    32'(ov_cnt - ov0),   32'd1);
    check("bp_no_xfer",    32'(xfer_cnt - x0),  32'd0);
    @(posedge clk);
    #1;
    m_if.m_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_one_xfer",   32'(xfer_cnt - x0),  32'd1);
    check("bp_valid_clr",  32'(m_if.m_valid),   32'd0);
    check("bp_sb_empty",   32'(exp_q.size()),   32'd0);

    // Glitch on the line, then a real frame
    @(posedge clk);
    #1;
    snap();
    uart_rxd = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    repeat (BPS * 2) @(posedge clk);
    #1;
    check("glitch_no_valid", 32'(xfer_cnt - x0), 32'd0);
    check("glitch_no_fe",    32'(fe_cnt - fe0),  32'd0);
    exp_q.push_back(8'h55);
    send(8'h55, 1'b0, 1'b1);
    repeat (BPS) @(posedge clk);
    #1;
    check("post_glitch_rx", 32'(xfer_cnt - x0), 32'd1);

    // Framing error followed by a break of 3 more bit times
    snap();
    send(8'h0F, 1'b0, 1'b0);
    uart_rxd = 1'b0;
    repeat (BPS * 3) @(posedge clk);
    #1;
    check("fe_in_break",  32'(fe_cnt - fe0),  32'd1);
    check("fe_no_valid",  32'(xfer_cnt - x0), 32'd0);
    uart_rxd = 1'b1;
    repeat (BPS) @(posedge clk);
    #1;
    exp_q.push_back(8'hF0);
    send(8'hF0, 1'b0, 1'b1);
    repeat (BPS) @(posedge clk);
    #1;
    check("fe_single",     32'(fe_cnt - fe0),  32'd1);
    check("post_fe_rx",    32'(xfer_cnt - x0), 32'd1);

    // Reset during data bit 4 of 0x81
    snap();
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(i == 0);
    uart_rxd = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(m_if.m_valid),   32'd0);
    check("mid_rst_data",  32'(m_if.m_data),    32'd0);
    check("mid_rst_fe",    32'(m_if.frame_err), 32'd0);
    check("mid_rst_ov",    32'(m_if.overrun),   32'd0);
    uart_rxd = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (BPS) @(posedge clk);
    #1;
    check("mid_rst_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b0, 1'b1);
    repeat (BPS) @(posedge clk);
    #1;
    check("post_rst_rx", 32'(xfer_cnt - x0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x01 needs parity bit 1
    snap();
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1, 1'b1);
    send(8'h01, 1'b0, 1'b1);
    repeat (BPS) @(posedge clk);
    #1;
    check("par_xfers", 32'(xfer_cnt - x0), 32'd1);
    check("par_err",   32'(pe_cnt - pe0),  32'd1);
    check("par_no_ov", 32'(ov_cnt - ov0),  32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
